// File: rtl/decoder_scan_pkg.sv
// Shared mode and state encodings for the scanning decoder.
package decoder_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_core.sv
// Combinational N-to-2^N decoder with enable and selectable active level.
module decoder_core #(
  parameter int unsigned N          = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic [N-1:0]        sel,
  input  logic                en,
  output logic [(1<<N)-1:0]   dec_c
);

  localparam int unsigned W = 1 << N;

  logic [W-1:0] hot;

  // One-hot pattern first; inversion gives the one-cold form.
  always_comb begin
    hot = '0;
    if (en) begin
      hot[sel] = 1'b1;
    end
    dec_c = ACTIVE_LOW ? ~hot : hot;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with a DIRECT select mode and a prescaled SCAN mode.
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                E,
  input  logic                mode,
  input  logic [N-1:0]        In,
  output logic [(1<<N)-1:0]   Out,
  output logic [N-1:0]        Idx,
  output logic                Wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = N'(W - 1);
  localparam logic [W-1:0]  INACTIVE = {W{ACTIVE_LOW}};

  state_t          state, state_n;
  logic [PW-1:0]   pre, pre_n;
  logic [N-1:0]    idx_n;
  logic            en_c;
  logic            wrap_n;
  logic [W-1:0]    out_c;

  // Decode the index that will be held next, so Out and Idx always agree.
  decoder_core #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .sel   (idx_n),
    .en    (en_c),
    .dec_c (out_c)
  );

  // State, prescaler and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DIRECT;
      pre   <= '0;
      Idx   <= '0;
      Out   <= INACTIVE;
      Wrap  <= 1'b0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      Idx   <= idx_n;
      Out   <= out_c;
      Wrap  <= wrap_n;
    end
  end

  // Next-state, prescaler and index selection.
  always_comb begin
    state_n = state;
    pre_n   = pre;
    idx_n   = Idx;
    en_c    = 1'b0;
    wrap_n  = 1'b0;
    unique case (state)
      ST_DIRECT: begin
        idx_n = In;
        en_c  = E;
        pre_n = '0;
        if (mode == MODE_SCAN) begin
          state_n = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mode == MODE_DIRECT) begin
          // Leaving scan: hold the index, no advance and no wrap on the exit edge.
          state_n = ST_DIRECT;
          pre_n   = '0;
          en_c    = E;
        end else if (E) begin
          en_c = 1'b1;
          if (pre == PRE_LAST) begin
            pre_n  = '0;
            idx_n  = N'(Idx + 1'b1);
            wrap_n = (Idx == IDX_LAST);
          end else begin
            pre_n = PW'(pre + 1'b1);
          end
        end
      end
      default: begin
        state_n = ST_DIRECT;
        pre_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Randomised and directed bench for decoder_scan against a behavioural model.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, E, mode;
  logic [2:0] in3;
  logic [1:0] in2;

  logic [7:0] out_a, out_b;
  logic [3:0] out_c;
  logic [2:0] idx_a, idx_b;
  logic [1:0] idx_c;
  logic       wrap_a, wrap_b, wrap_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign in2 = in3[1:0];

  decoder_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .In(in3),
    .Out(out_a), .Idx(idx_a), .Wrap(wrap_a));

  decoder_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .In(in3),
    .Out(out_b), .Idx(idx_b), .Wrap(wrap_b));

  decoder_scan #(.N(2), .DIV(1), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .In(in2),
    .Out(out_c), .Idx(idx_c), .Wrap(wrap_c));

  // Behavioural model: scan position as enabled-tick count, advancing every div ticks.
  typedef struct {
    int size;
    int div;
    bit al;
    bit scan;
    int idx;
    int ticks;
    bit wrap;
    bit lit;
  } mdl_t;

  mdl_t m [3];

  function automatic mdl_t upd(mdl_t s, bit r, bit e, bit md, int in_v);
    mdl_t t = s;
    t.wrap = 1'b0;
    if (r) begin
      t.scan = 1'b0; t.idx = 0; t.ticks = 0; t.lit = 1'b0;
    end else if (!t.scan) begin
      t.idx = in_v % t.size; t.lit = e; t.ticks = 0; t.scan = md;
    end else if (!md) begin
      t.scan = 1'b0; t.ticks = 0; t.lit = e;
    end else if (!e) begin
      t.lit = 1'b0;
    end else begin
      t.lit = 1'b1;
      t.ticks = t.ticks + 1;
      if (t.ticks == t.div) begin
        t.ticks = 0;
        t.idx = (t.idx + 1) % t.size;
        t.wrap = (t.idx == 0);
      end
    end
    return t;
  endfunction

  function automatic logic [31:0] exp_out(mdl_t s);
    logic [31:0] v = s.lit ? (32'd1 << s.idx) : 32'd0;
    logic [31:0] mask = (32'd1 << s.size) - 32'd1;
    if (s.al) v = ~v;
    return v & mask;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_a",  {24'd0, out_a},  exp_out(m[0]));
    chk("idx_a",  {29'd0, idx_a},  32'(m[0].idx));
    chk("wrap_a", {31'd0, wrap_a}, {31'd0, m[0].wrap});
    chk("out_b",  {24'd0, out_b},  exp_out(m[1]));
    chk("idx_b",  {29'd0, idx_b},  32'(m[1].idx));
    chk("wrap_b", {31'd0, wrap_b}, {31'd0, m[1].wrap});
    chk("out_c",  {28'd0, out_c},  exp_out(m[2]));
    chk("idx_c",  {30'd0, idx_c},  32'(m[2].idx));
    chk("wrap_c", {31'd0, wrap_c}, {31'd0, m[2].wrap});
  endtask

  // Drive inputs, clock once, advance the models and compare.
  task automatic step(bit r, bit e, bit md, logic [2:0] i);
    rst = r; E = e; mode = md; in3 = i;
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = upd(m[k], r, e, md, int'(i));
    #1;
    check_all();
  endtask

  initial begin
    m[0] = '{size: 8, div: 4, al: 1'b0, scan: 1'b0, idx: 0, ticks: 0, wrap: 1'b0, lit: 1'b0};
    m[1] = '{size: 8, div: 4, al: 1'b1, scan: 1'b0, idx: 0, ticks: 0, wrap: 1'b0, lit: 1'b0};
    m[2] = '{size: 4, div: 1, al: 1'b0, scan: 1'b0, idx: 0, ticks: 0, wrap: 1'b0, lit: 1'b0};

    // Reset with E=1, mode=1 held.
    step(1'b1, 1'b1, 1'b1, 3'd5);
    step(1'b1, 1'b1, 1'b1, 3'd5);
    chk("rst_out_low",  {24'd0, out_a}, 32'h00);
    chk("rst_out_high", {24'd0, out_b}, 32'hFF);

    // DIRECT sweep, then disable.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'(i));
      chk("direct_sweep", {24'd0, out_a}, 32'd1 << i);
    end
    step(1'b0, 1'b0, 1'b0, 3'd7);
    chk("direct_off", {24'd0, out_a}, 32'h00);

    // Enter SCAN from index 5 and run through the wrap.
    step(1'b0, 1'b1, 1'b0, 3'd5);
    step(1'b0, 1'b1, 1'b1, 3'd5);
    chk("scan_first", {24'd0, out_a}, 32'h20);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 3'd0);

    // Freeze mid-scan: E low for 5 cycles, then resume.
    step(1'b0, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 3'd0);
    chk("freeze_out", {24'd0, out_a}, 32'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 3'd0);

    // Reset mid-scan, then toggle mode on consecutive cycles.
    step(1'b1, 1'b1, 1'b1, 3'd2);
    chk("rst_mid_idx", {29'd0, idx_a}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 3'd6);
    step(1'b0, 1'b1, 1'b0, 3'd6);
    step(1'b0, 1'b1, 1'b1, 3'd6);
    step(1'b0, 1'b1, 1'b0, 3'd6);
    step(1'b0, 1'b1, 1'b1, 3'd6);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 3'd0);

    // Random stimulus.
    begin
      bit md = 1'b0;
      for (int i = 0; i < 400; i++) begin
        bit r = ($urandom_range(0, 31) == 0);
        bit e = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 7) == 0) md = ~md;
        step(r, e, md, 3'($urandom_range(0, 7)));
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
